grid_ram_mp: RTL and testbench
==============================

Name: grid_ram_mp

Overview:
- Parametrised successor to the team's row/column-addressed dual-port RAM.
- Provides one write port, NUM_RD independent registered read ports with valid flags, and optional write-to-read forwarding.
- Includes a sequential row-clear engine that zeroes one row, one column per cycle.
- Sits between producers and consumers of 2D tile data (matrix/frame buffers); replaces hard-wired debug taps with generic read ports.

Parameters:
DATA_WIDTH, 8, width of each element
ROWS, 4, number of rows (need not be a power of two)
COLS, 32, number of columns (need not be a power of two)
NUM_RD, 3, number of read ports (>=1)
RD_BYPASS, 1, 1 = same-cycle write to the read address is forwarded to the read; 0 = read returns the old contents
RW = max(1,$clog2(ROWS)), CW = max(1,$clog2(COLS)): localparams

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
we  in  1  write enable
w_row  in  RW  write row
w_col  in  CW  write column
din  in  DATA_WIDTH  write data
rd_en  in  NUM_RD  per-port read request
rd_row  in  NUM_RD*RW  packed row addresses; port i at [i*RW +: RW]
rd_col  in  NUM_RD*CW  packed column addresses; port i at [i*CW +: CW]
rd_data  out  NUM_RD*DATA_WIDTH  packed read data
rd_valid  out  NUM_RD  read data valid
clr_req  in  1  start row clear (sampled when idle)
clr_row  in  RW  row to clear
clr_busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse after the last column is cleared

Behaviour:
- Clock is clk. Reset is rst: asynchronous and active-high.
- Reset values:
  - rd_data = 0, rd_valid = 0, clr_busy = 0, clr_done = 0.
  - FSM goes to IDLE; column counter = 0.
  - Memory array is NOT reset.
- Write: at a clk edge with we=1 and an in-range address, mem[w_row][w_col] <= din.
  - Out-of-range address (w_row>=ROWS or w_col>=COLS): write dropped.
- Read, per port i, latency 1:
  - rd_en[i]=1 at edge N -> rd_data[i] and rd_valid[i]=1 valid after edge N.
  - rd_en[i]=0 -> rd_valid[i]=0 next cycle; rd_data[i] holds its previous value.
  - Out-of-range read address -> rd_data[i]=0 with rd_valid[i]=1.
- Forwarding:
  - If the effective write in cycle N (user or clear) hits port i's read address in the same cycle:
    - RD_BYPASS=1: returns the written value.
    - RD_BYPASS=0: returns the pre-write contents.
  - All ports may read the same address simultaneously.
- Clear FSM, states IDLE, CLEAR:
  - IDLE: clr_req=1 -> latch clr_row, col_cnt=0, go to CLEAR.
    - clr_busy rises the cycle after the request.
    - clr_row >= ROWS: request ignored, FSM stays IDLE.
  - CLEAR: each cycle writes 0 to mem[row_l][col_cnt], then col_cnt++.
    - At col_cnt==COLS-1: write, go to IDLE, pulse clr_done for one cycle; clr_busy falls on the same edge.
    - Total busy duration is exactly COLS cycles.
  - clr_req while CLEAR: ignored, not queued.
- Collision, user write and clear on the same cell in the same cycle: user write wins; the clear counter still advances.
  - A user write during CLEAR to a column of row_l not yet reached is overwritten with 0 later.
  - User writes to other rows proceed normally.
- Reads are never stalled by a clear.
- Reset asserted mid-clear: FSM aborts to IDLE immediately; the row is left partially cleared; no clr_done pulse.

Decomposition:
- Shared package grid_ram_pkg holds:
  - localparam function for safe clog2 (min 1);
  - clear FSM state typedef (IDLE=0, CLEAR=1).
- One sub-module, grid_ram_rdport: per-port address range check, forwarding mux, and output registers.
  - Instantiated NUM_RD times in a generate loop.
- The top level holds the array, the write-arbitration mux (user vs. clear), and the clear FSM.

Test Plan:
- Write 0xA5 to (2,7), then on the next cycle port 0 reads (2,7) -> after 1 cycle rd_data[0]=0xA5, rd_valid[0]=1; the following cycle with rd_en=0 -> rd_valid[0]=0, data held at 0xA5.
- RD_BYPASS=1: mem(1,3)=0x11, same cycle write 0x22 to (1,3) and read (1,3) on all 3 ports -> all return 0x22. Repeat with RD_BYPASS=0 -> all return 0x11.
- Fill row 3 with 0xFF, assert clr_req with clr_row=3 -> clr_busy high for exactly 32 cycles, clr_done pulses once, all 32 reads of row 3 return 0x00; row 2 is untouched.
- During the clear of row 0, write 0x5A to (0,col_cnt) in the collision cycle and 0x66 to (1,4) -> (0,that col)=0x5A, (1,4)=0x66. A write of 0x77 to (0,31) issued at col_cnt=5 reads back as 0x00 after clr_done.
- Assert rst at col_cnt=10 of a clear of row 1 -> clr_busy=0 and all rd_valid=0 immediately, no clr_done; columns 0..9 = 0, columns 10..31 keep their old values.
- ROWS=3: write to row 3 and read row 3 -> write dropped, read returns 0 with valid; clr_req with clr_row=3 -> clr_busy stays 0.

Source files
------------

// File: rtl/grid_ram_pkg.sv
// rtl/grid_ram_pkg.sv - shared helpers and clear-engine state type for grid_ram_mp
package grid_ram_pkg;

  function automatic int safe_clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/grid_ram_rdport.sv
// rtl/grid_ram_rdport.sv - one registered read port with range check and write forwarding
module grid_ram_rdport
  import grid_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 32,
  parameter int RD_BYPASS  = 1,
  parameter int RW         = 2,
  parameter int CW         = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [RW-1:0]         rd_row,
  input  logic [CW-1:0]         rd_col,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  uw_en,
  input  logic [RW-1:0]         uw_row,
  input  logic [CW-1:0]         uw_col,
  input  logic [DATA_WIDTH-1:0] uw_data,
  input  logic                  cw_en,
  input  logic [RW-1:0]         cw_row,
  input  logic [CW-1:0]         cw_col,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  logic                  in_range;
  logic                  uw_hit;
  logic                  cw_hit;
  logic [DATA_WIDTH-1:0] rd_next;

  assign in_range = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);
  assign uw_hit   = uw_en && (uw_row == rd_row) && (uw_col == rd_col);
  assign cw_hit   = cw_en && (cw_row == rd_row) && (cw_col == rd_col);

  // The user write has priority over the clear write, mirroring the array.
  always_comb begin
    rd_next = mem_data;
    if (RD_BYPASS != 0) begin
      if (uw_hit)
        rd_next = uw_data;
      else if (cw_hit)
        rd_next = '0;
    end
    if (!in_range)
      rd_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en)
        rd_data <= rd_next;
    end
  end

endmodule

// File: rtl/grid_ram_mp.sv
// rtl/grid_ram_mp.sv - row/column RAM with one write port, NUM_RD read ports and a row-clear engine
module grid_ram_mp
  import grid_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 4,
  parameter int COLS       = 32,
  parameter int NUM_RD     = 3,
  parameter int RD_BYPASS  = 1,
  localparam int RW        = safe_clog2(ROWS),
  localparam int CW        = safe_clog2(COLS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [RW-1:0]                w_row,
  input  logic [CW-1:0]                w_col,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*RW-1:0]         rd_row,
  input  logic [NUM_RD*CW-1:0]         rd_col,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  input  logic                         clr_req,
  input  logic [RW-1:0]                clr_row,
  output logic                         clr_busy,
  output logic                         clr_done
);

  logic [DATA_WIDTH-1:0] mem [ROWS][COLS];

  clr_state_t    state, state_n;
  logic [CW-1:0] col_cnt, col_n;
  logic [RW-1:0] row_l, row_n;
  logic          done_n;
  logic          uw_en;
  logic          cw_en;

  assign uw_en    = we && (int'(w_row) < ROWS) && (int'(w_col) < COLS);
  assign cw_en    = (state == CLEAR);
  assign clr_busy = (state == CLEAR);

  // Both writes may land in one cycle; the later assignment lets the user write win a shared cell.
  always_ff @(posedge clk) begin
    if (cw_en)
      mem[row_l][col_cnt] <= '0;
    if (uw_en)
      mem[w_row][w_col] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      col_cnt  <= '0;
      row_l    <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_n;
      col_cnt  <= col_n;
      row_l    <= row_n;
      clr_done <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    col_n   = col_cnt;
    row_n   = row_l;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req && (int'(clr_row) < ROWS)) begin
          state_n = CLEAR;
          col_n   = '0;
          row_n   = clr_row;
        end
      end
      CLEAR: begin
        if (col_cnt == CW'(COLS - 1)) begin
          state_n = IDLE;
          col_n   = '0;
          done_n  = 1'b1;
        end else begin
          col_n = col_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [RW-1:0] p_row;
    logic [CW-1:0] p_col;

    assign p_row = rd_row[g*RW +: RW];
    assign p_col = rd_col[g*CW +: CW];

    grid_ram_rdport #(
      .DATA_WIDTH(DATA_WIDTH),
      .ROWS      (ROWS),
      .COLS      (COLS),
      .RD_BYPASS (RD_BYPASS),
      .RW        (RW),
      .CW        (CW)
    ) u_rdport (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (rd_en[g]),
      .rd_row  (p_row),
      .rd_col  (p_col),
      .mem_data(mem[p_row][p_col]),
      .uw_en   (uw_en),
      .uw_row  (w_row),
      .uw_col  (w_col),
      .uw_data (din),
      .cw_en   (cw_en),
      .cw_row  (row_l),
      .cw_col  (col_cnt),
      .rd_data (rd_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .rd_valid(rd_valid[g])
    );
  end

endmodule

// File: tb/tb_grid_ram_mp.sv
// tb/tb_grid_ram_mp.sv - directed bench for grid_ram_mp (bypass, no-bypass and ROWS=3 instances)
module tb_grid_ram_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [1:0]  w_row = '0;
  logic [4:0]  w_col = '0;
  logic [7:0]  din = '0;
  logic [2:0]  rd_en = '0;
  logic [5:0]  rd_row = '0;
  logic [14:0] rd_col = '0;
  logic        clr_req = 1'b0;
  logic [1:0]  clr_row = '0;

  logic [23:0] rd_data_a, rd_data_b, rd_data_c;
  logic [2:0]  rd_valid_a, rd_valid_b, rd_valid_c;
  logic        clr_busy_a, clr_busy_b, clr_busy_c;
  logic        clr_done_a, clr_done_b, clr_done_c;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  grid_ram_mp #(.RD_BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .we(we), .w_row(w_row), .w_col(w_col), .din(din),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .clr_req(clr_req), .clr_row(clr_row), .clr_busy(clr_busy_a), .clr_done(clr_done_a)
  );

  grid_ram_mp #(.RD_BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .we(we), .w_row(w_row), .w_col(w_col), .din(din),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .clr_req(clr_req), .clr_row(clr_row), .clr_busy(clr_busy_b), .clr_done(clr_done_b)
  );

  grid_ram_mp #(.ROWS(3)) dut_c (
    .clk(clk), .rst(rst), .we(we), .w_row(w_row), .w_col(w_col), .din(din),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
    .clr_req(clr_req), .clr_row(clr_row), .clr_busy(clr_busy_c), .clr_done(clr_done_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [1:0] r, input logic [4:0] c);
    rd_row[p*2 +: 2] = r;
    rd_col[p*5 +: 5] = c;
  endtask

  task automatic write_cell(input logic [1:0] r, input logic [4:0] c, input logic [7:0] d);
    we = 1'b1; w_row = r; w_col = c; din = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    tests_run++;
    if (rd_valid_a !== 3'b000 || rd_data_a !== 24'h0) begin
      $display("FAIL reset_rd valid=%b data=%h exp 000/000000", rd_valid_a, rd_data_a);
      tests_failed++;
    end
    tests_run++;
    if (clr_busy_a !== 1'b0 || clr_done_a !== 1'b0) begin
      $display("FAIL reset_clr busy=%b done=%b exp 0/0", clr_busy_a, clr_done_a);
      tests_failed++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    write_cell(2'd2, 5'd7, 8'hA5);
    rd_en = 3'b001;
    set_rd(0, 2'd2, 5'd7);
    tick();
    tests_run++;
    if (rd_data_a[7:0] !== 8'hA5 || rd_valid_a[0] !== 1'b1) begin
      $display("FAIL write_read data=%h valid=%b exp a5/1", rd_data_a[7:0], rd_valid_a[0]);
      tests_failed++;
    end
    rd_en = 3'b000;
    tick();
    tests_run++;
    if (rd_data_a[7:0] !== 8'hA5 || rd_valid_a[0] !== 1'b0) begin
      $display("FAIL read_hold data=%h valid=%b exp a5/0", rd_data_a[7:0], rd_valid_a[0]);
      tests_failed++;
    end
  endtask

  task automatic test_bypass();
    write_cell(2'd1, 5'd3, 8'h11);
    we = 1'b1; w_row = 2'd1; w_col = 5'd3; din = 8'h22;
    rd_en = 3'b111;
    for (int p = 0; p < 3; p++) set_rd(p, 2'd1, 5'd3);
    tick();
    we = 1'b0;
    rd_en = 3'b000;
    tests_run++;
    if (rd_data_a !== 24'h222222 || rd_valid_a !== 3'b111) begin
      $display("FAIL bypass_on data=%h valid=%b exp 222222/111", rd_data_a, rd_valid_a);
      tests_failed++;
    end
    tests_run++;
    if (rd_data_b !== 24'h111111 || rd_valid_b !== 3'b111) begin
      $display("FAIL bypass_off data=%h valid=%b exp 111111/111", rd_data_b, rd_valid_b);
      tests_failed++;
    end
  endtask

  task automatic test_clear();
    int busy_cycles = 0;
    int early_done = 0;
    for (int c = 0; c < 32; c++) write_cell(2'd3, 5'(c), 8'hFF);
    write_cell(2'd2, 5'd5, 8'h3C);
    clr_req = 1'b1; clr_row = 2'd3;
    tick();
    clr_req = 1'b0;
    while (clr_busy_a === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      if (clr_done_a !== 1'b0) early_done++;
      tick();
    end
    tests_run++;
    if (busy_cycles != 32 || early_done != 0) begin
      $display("FAIL clear_busy cycles=%0d early_done=%0d exp 32/0", busy_cycles, early_done);
      tests_failed++;
    end
    tests_run++;
    if (clr_done_a !== 1'b1) begin
      $display("FAIL clear_done_pulse done=%b exp 1", clr_done_a);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (clr_done_a !== 1'b0) begin
      $display("FAIL clear_done_once done=%b exp 0", clr_done_a);
      tests_failed++;
    end
    rd_en = 3'b001;
    for (int c = 0; c < 32; c++) begin
      set_rd(0, 2'd3, 5'(c));
      tick();
      tests_run++;
      if (rd_data_a[7:0] !== 8'h00) begin
        $display("FAIL clear_row3 col=%0d data=%h exp 00", c, rd_data_a[7:0]);
        tests_failed++;
      end
    end
    set_rd(0, 2'd2, 5'd5);
    tick();
    rd_en = 3'b000;
    tests_run++;
    if (rd_data_a[7:0] !== 8'h3C) begin
      $display("FAIL clear_row2_intact data=%h exp 3c", rd_data_a[7:0]);
      tests_failed++;
    end
  endtask

  task automatic test_collision();
    clr_req = 1'b1; clr_row = 2'd0;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      we = 1'b0;
      rd_en = 3'b000;
      if (k == 5) begin we = 1'b1; w_row = 2'd0; w_col = 5'd31; din = 8'h77; end
      if (k == 6) begin we = 1'b1; w_row = 2'd1; w_col = 5'd4;  din = 8'h66; end
      if (k == 8) begin
        we = 1'b1; w_row = 2'd0; w_col = 5'd8; din = 8'h5A;
        rd_en = 3'b010;
        set_rd(1, 2'd0, 5'd8);
      end
      tick();
      if (k == 8) begin
        tests_run++;
        if (rd_data_a[15:8] !== 8'h5A) begin
          $display("FAIL collision_fwd data=%h exp 5a", rd_data_a[15:8]);
          tests_failed++;
        end
      end
    end
    we = 1'b0;
    rd_en = 3'b000;
    tests_run++;
    if (clr_done_a !== 1'b1 || clr_busy_a !== 1'b0) begin
      $display("FAIL collision_done done=%b busy=%b exp 1/0", clr_done_a, clr_busy_a);
      tests_failed++;
    end
    rd_en = 3'b111;
    set_rd(0, 2'd0, 5'd8);
    set_rd(1, 2'd0, 5'd31);
    set_rd(2, 2'd1, 5'd4);
    tick();
    rd_en = 3'b000;
    tests_run++;
    if (rd_data_a !== 24'h66_00_5A) begin
      $display("FAIL collision_result data=%h exp 66005a", rd_data_a);
      tests_failed++;
    end
  endtask

  task automatic test_reset_mid_clear();
    int bad = 0;
    for (int c = 0; c < 32; c++) write_cell(2'd1, 5'(c), 8'(c + 1));
    clr_req = 1'b1; clr_row = 2'd1;
    tick();
    clr_req = 1'b0;
    rd_en = 3'b111;
    for (int p = 0; p < 3; p++) set_rd(p, 2'd2, 5'd5);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (clr_busy_a !== 1'b0 || rd_valid_a !== 3'b000 || clr_done_a !== 1'b0) begin
      $display("FAIL reset_abort busy=%b valid=%b done=%b exp 0/000/0", clr_busy_a, rd_valid_a, clr_done_a);
      tests_failed++;
    end
    rd_en = 3'b000;
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      if (clr_done_a !== 1'b0 || clr_busy_a !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      $display("FAIL reset_no_done bad_cycles=%0d exp 0", bad);
      tests_failed++;
    end
    rd_en = 3'b001;
    for (int c = 0; c < 32; c++) begin
      logic [7:0] exp_v;
      exp_v = (c < 10) ? 8'h00 : 8'(c + 1);
      set_rd(0, 2'd1, 5'(c));
      tick();
      tests_run++;
      if (rd_data_a[7:0] !== exp_v) begin
        $display("FAIL partial_clear col=%0d data=%h exp %h", c, rd_data_a[7:0], exp_v);
        tests_failed++;
      end
    end
    rd_en = 3'b000;
  endtask

  task automatic test_rows3();
    write_cell(2'd3, 5'd0, 8'h99);
    rd_en = 3'b001;
    set_rd(0, 2'd3, 5'd0);
    tick();
    rd_en = 3'b000;
    tests_run++;
    if (rd_data_c[7:0] !== 8'h00 || rd_valid_c[0] !== 1'b1) begin
      $display("FAIL rows3_read data=%h valid=%b exp 00/1", rd_data_c[7:0], rd_valid_c[0]);
      tests_failed++;
    end
    tests_run++;
    if (rd_data_a[7:0] !== 8'h99) begin
      $display("FAIL rows4_read data=%h exp 99", rd_data_a[7:0]);
      tests_failed++;
    end
    clr_req = 1'b1; clr_row = 2'd3;
    tick();
    clr_req = 1'b0;
    tests_run++;
    if (clr_busy_c !== 1'b0 || clr_busy_a !== 1'b1) begin
      $display("FAIL rows3_clr busy_c=%b busy_a=%b exp 0/1", clr_busy_c, clr_busy_a);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (clr_busy_c !== 1'b0) begin
      $display("FAIL rows3_clr_stay busy_c=%b exp 0", clr_busy_c);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_collision();
    test_reset_mid_clear();
    test_rows3();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
